// File: rtl/ppi_bus_pkg.sv
// rtl/ppi_bus_pkg.sv - shared constants and FSM encoding for the PPI bus master
package ppi_bus_pkg;

    localparam logic [1:0] PPI_PORT_A = 2'd0;
    localparam logic [1:0] PPI_PORT_B = 2'd1;
    localparam logic [1:0] PPI_PORT_C = 2'd2;
    localparam logic [1:0] PPI_CTRL   = 2'd3;

    // Bit 7 of a control-register write selects mode-set versus bit set/reset.
    localparam int   CTRL_FLAG_BIT = 7;
    localparam logic CTRL_MODE_SET = 1'b1;
    localparam logic CTRL_BSR      = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } ppiState_e;

    function automatic logic isModeSet(input logic [7:0] ctrlWord);
        return ctrlWord[CTRL_FLAG_BIT] == CTRL_MODE_SET;
    endfunction

endpackage

// File: rtl/ppi_bus_master_if.sv
// rtl/ppi_bus_master_if.sv - request/response handshake and PPI bus control signals
interface ppi_bus_master_if;

    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [1:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] A;
    logic       CS;
    logic       READ;
    logic       WRITE;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata,
        output A, CS, READ, WRITE
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata,
        input  A, CS, READ, WRITE
    );

endinterface

// File: rtl/ppi_phase_timer.sv
// rtl/ppi_phase_timer.sv - loadable 4-bit down counter timing the setup/strobe/hold phases
module ppi_phase_timer (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       load,
    input  logic [3:0] loadValue,
    output logic       expired
);

    logic [3:0] count;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            count <= 4'd0;
        end else if (load) begin
            count <= loadValue;
        end else if (count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    // A phase loaded with N lasts N cycles; the last one is flagged so the FSM can move on.
    assign expired = (count <= 4'd1);

endmodule

// File: rtl/ppi_bus_master.sv
// rtl/ppi_bus_master.sv - timed single-transfer initiator for the 8255-style PPI bus
module ppi_bus_master
    import ppi_bus_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    ppi_bus_master_if.master  bus,
    inout  wire  [7:0]        DATA
);

    generate
        if (SETUP_CYC < 1 || SETUP_CYC > 15 || STROBE_CYC < 1 || STROBE_CYC > 15 ||
            HOLD_CYC < 1 || HOLD_CYC > 15) begin : gBadTiming
            $error("ppi_bus_master: phase lengths must be in 1..15");
        end
    endgenerate

    ppiState_e  state, nextState;
    logic       timerLoad, timerExpired, captureRead;
    logic [3:0] timerValue;
    logic       accept, wrNext, busActive;

    logic       wrQ, readyQ, csQ, readQ, writeQ, oeQ, rspValidQ;
    logic [1:0] addrQ;
    logic [7:0] wdataQ, rspRdataQ;

    ppi_phase_timer uTimer (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .load      (timerLoad),
        .loadValue (timerValue),
        .expired   (timerExpired)
    );

    always_comb begin
        nextState   = state;
        timerLoad   = 1'b0;
        timerValue  = 4'(SETUP_CYC);
        captureRead = 1'b0;
        case (state)
            IDLE: if (bus.req_valid) begin
                nextState  = SETUP;
                timerLoad  = 1'b1;
                timerValue = 4'(SETUP_CYC);
            end
            SETUP: if (timerExpired) begin
                nextState  = STROBE;
                timerLoad  = 1'b1;
                timerValue = 4'(STROBE_CYC);
            end
            STROBE: if (timerExpired) begin
                nextState   = HOLD;
                timerLoad   = 1'b1;
                timerValue  = 4'(HOLD_CYC);
                captureRead = !wrQ;
            end
            HOLD:    if (timerExpired) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so every pin changes right after the edge.
    assign accept    = (state == IDLE) && bus.req_valid;
    assign wrNext    = accept ? bus.req_write : wrQ;
    assign busActive = (nextState == SETUP) || (nextState == STROBE) || (nextState == HOLD);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state     <= IDLE;
            wrQ       <= 1'b0;
            addrQ     <= 2'd0;
            wdataQ    <= 8'h00;
            readyQ    <= 1'b1;
            csQ       <= 1'b1;
            readQ     <= 1'b1;
            writeQ    <= 1'b1;
            oeQ       <= 1'b0;
            rspValidQ <= 1'b0;
            rspRdataQ <= 8'h00;
        end else begin
            state <= nextState;
            if (accept) begin
                wrQ    <= bus.req_write;
                addrQ  <= bus.req_addr;
                wdataQ <= bus.req_wdata;
            end
            readyQ    <= (nextState == IDLE);
            csQ       <= !busActive;
            readQ     <= !((nextState == STROBE) && !wrNext);
            writeQ    <= !((nextState == STROBE) && wrNext);
            oeQ       <= busActive && wrNext;
            rspValidQ <= (nextState == DONE);
            if (captureRead) rspRdataQ <= DATA;
        end
    end

    assign DATA          = oeQ ? wdataQ : 8'hzz;
    assign bus.req_ready = readyQ;
    assign bus.rsp_valid = rspValidQ;
    assign bus.rsp_rdata = rspRdataQ;
    assign bus.A         = addrQ;
    assign bus.CS        = csQ;
    assign bus.READ      = readQ;
    assign bus.WRITE     = writeQ;

endmodule

// File: tb/tb_ppi_bus_master.sv
// tb/tb_ppi_bus_master.sv - directed self-checking bench for ppi_bus_master
module tb_ppi_bus_master;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    ppi_bus_master_if bus0();
    ppi_bus_master_if bus1();
    wire [7:0] DATA0;
    wire [7:0] DATA1;
    pullup (DATA0);
    pullup (DATA1);

    logic [7:0] model0 = 8'h00;
    logic [7:0] model1 = 8'h00;

    // PPI models drive the bus only while the read strobe is low.
    assign DATA0 = (bus0.READ == 1'b0) ? model0 : 8'hzz;
    assign DATA1 = (bus1.READ == 1'b0) ? model1 : 8'hzz;

    ppi_bus_master uDut0 (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus0.master),
        .DATA    (DATA0)
    );

    ppi_bus_master #(.SETUP_CYC(2), .STROBE_CYC(4), .HOLD_CYC(3)) uDut1 (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus1.master),
        .DATA    (DATA1)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        bus0.req_valid = 0; bus0.req_write = 0; bus0.req_addr = 0; bus0.req_wdata = 0;
        bus1.req_valid = 0; bus1.req_write = 0; bus1.req_addr = 0; bus1.req_wdata = 0;
        RESET_N = 0;
        tick(); tick();
        RESET_N = 1;
        checks++; if (bus0.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus0.req_ready); end
        checks++; if ({bus0.CS, bus0.READ, bus0.WRITE} !== 3'b111) begin errors++; $display("FAIL reset_strobes got %b want 111", {bus0.CS, bus0.READ, bus0.WRITE}); end
        checks++; if (bus0.A !== 2'b00) begin errors++; $display("FAIL reset_addr got %b want 00", bus0.A); end
        checks++; if (bus0.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus0.rsp_valid); end
        checks++; if (bus0.rsp_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", bus0.rsp_rdata); end
        checks++; if (DATA0 !== 8'hFF) begin errors++; $display("FAIL reset_data_released got %h want ff", DATA0); end
        checks++; if (bus1.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_long got %b want 1", bus1.req_ready); end
    endtask

    task automatic test_write();
        bus0.req_valid = 1; bus0.req_write = 1; bus0.req_addr = 2'd3; bus0.req_wdata = 8'h80;
        tick();
        bus0.req_valid = 0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            checks++; if (bus0.CS !== (cyc <= 4 ? 1'b0 : 1'b1)) begin errors++; $display("FAIL wr_cs cyc %0d got %b", cyc, bus0.CS); end
            checks++; if (bus0.WRITE !== ((cyc == 2 || cyc == 3) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL wr_strobe cyc %0d got %b", cyc, bus0.WRITE); end
            checks++; if (bus0.READ !== 1'b1) begin errors++; $display("FAIL wr_read cyc %0d got %b want 1", cyc, bus0.READ); end
            checks++; if (DATA0 !== (cyc <= 4 ? 8'h80 : 8'hFF)) begin errors++; $display("FAIL wr_data cyc %0d got %h", cyc, DATA0); end
            checks++; if (bus0.rsp_valid !== (cyc == 5)) begin errors++; $display("FAIL wr_rsp cyc %0d got %b", cyc, bus0.rsp_valid); end
            if (cyc <= 4) begin
                checks++; if (bus0.A !== 2'd3) begin errors++; $display("FAIL wr_addr cyc %0d got %0d want 3", cyc, bus0.A); end
            end
            tick();
        end
    endtask

    task automatic test_read();
        model0 = 8'h5A;
        bus0.req_valid = 1; bus0.req_write = 0; bus0.req_addr = 2'd0; bus0.req_wdata = 8'hC3;
        tick();
        bus0.req_valid = 0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            checks++; if (bus0.READ !== ((cyc == 2 || cyc == 3) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL rd_strobe cyc %0d got %b", cyc, bus0.READ); end
            checks++; if (bus0.WRITE !== 1'b1) begin errors++; $display("FAIL rd_write cyc %0d got %b want 1", cyc, bus0.WRITE); end
            checks++; if (DATA0 !== ((cyc == 2 || cyc == 3) ? 8'h5A : 8'hFF)) begin errors++; $display("FAIL rd_data_bus cyc %0d got %h", cyc, DATA0); end
            checks++; if (bus0.rsp_valid !== (cyc == 5)) begin errors++; $display("FAIL rd_rsp cyc %0d got %b", cyc, bus0.rsp_valid); end
            if (cyc == 5) begin
                checks++; if (bus0.rsp_rdata !== 8'h5A) begin errors++; $display("FAIL rd_rdata got %h want 5a", bus0.rsp_rdata); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        model0 = 8'h96;
        bus0.req_valid = 1; bus0.req_write = 0; bus0.req_addr = 2'd1; bus0.req_wdata = 8'h00;
        tick();
        bus0.req_write = 1; bus0.req_addr = 2'd2; bus0.req_wdata = 8'h3C;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            logic csLow;
            logic [7:0] expData;
            csLow = (cyc <= 4) || (cyc >= 7 && cyc <= 10);
            expData = (cyc == 2 || cyc == 3) ? 8'h96 : ((cyc >= 7 && cyc <= 10) ? 8'h3C : 8'hFF);
            if (cyc == 7) bus0.req_valid = 0;
            checks++; if (bus0.CS !== !csLow) begin errors++; $display("FAIL b2b_cs cyc %0d got %b want %b", cyc, bus0.CS, !csLow); end
            checks++; if (DATA0 !== expData) begin errors++; $display("FAIL b2b_data cyc %0d got %h want %h", cyc, DATA0, expData); end
            checks++; if (bus0.WRITE !== ((cyc == 8 || cyc == 9) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL b2b_write cyc %0d got %b", cyc, bus0.WRITE); end
            if (cyc == 5) begin
                checks++; if (bus0.rsp_rdata !== 8'h96) begin errors++; $display("FAIL b2b_rdata got %h want 96", bus0.rsp_rdata); end
                checks++; if (bus0.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_done got %b want 0", bus0.req_ready); end
            end
            if (cyc == 6) begin
                checks++; if (bus0.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_idle got %b want 1", bus0.req_ready); end
            end
            if (bus0.rsp_valid === 1'b1) pulses++;
            checks++; if (bus0.rsp_valid !== (cyc == 5 || cyc == 11)) begin errors++; $display("FAIL b2b_rsp cyc %0d got %b", cyc, bus0.rsp_valid); end
            tick();
        end
        checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulse_count got %0d want 2", pulses); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        bus0.req_valid = 1; bus0.req_write = 1; bus0.req_addr = 2'd1; bus0.req_wdata = 8'hA5;
        tick();
        bus0.req_valid = 0;
        tick();
        tick();
        checks++; if (bus0.WRITE !== 1'b0) begin errors++; $display("FAIL rst_mid_pre_strobe got %b want 0", bus0.WRITE); end
        RESET_N = 0;
        tick();
        checks++; if (bus0.WRITE !== 1'b1) begin errors++; $display("FAIL rst_mid_write got %b want 1", bus0.WRITE); end
        checks++; if (bus0.CS !== 1'b1) begin errors++; $display("FAIL rst_mid_cs got %b want 1", bus0.CS); end
        checks++; if (DATA0 !== 8'hFF) begin errors++; $display("FAIL rst_mid_data got %h want ff", DATA0); end
        checks++; if (bus0.req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", bus0.req_ready); end
        checks++; if (bus0.rsp_rdata !== 8'h00) begin errors++; $display("FAIL rst_mid_rdata got %h want 00", bus0.rsp_rdata); end
        RESET_N = 1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (bus0.rsp_valid === 1'b1) pulses++;
            tick();
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rst_mid_no_rsp got %0d pulses want 0", pulses); end
    endtask

    task automatic test_long_read();
        int lowCount = 0;
        model1 = 8'h11;
        bus1.req_valid = 1; bus1.req_write = 0; bus1.req_addr = 2'd2;
        tick();
        bus1.req_valid = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (cyc == 5) model1 = 8'h22;
            if (bus1.READ === 1'b0) lowCount++;
            checks++; if (bus1.READ !== ((cyc >= 3 && cyc <= 6) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL long_strobe cyc %0d got %b", cyc, bus1.READ); end
            checks++; if (bus1.rsp_valid !== (cyc == 10)) begin errors++; $display("FAIL long_rsp cyc %0d got %b", cyc, bus1.rsp_valid); end
            if (cyc == 10) begin
                checks++; if (bus1.rsp_rdata !== 8'h22) begin errors++; $display("FAIL long_rdata got %h want 22", bus1.rsp_rdata); end
            end
            tick();
        end
        checks++; if (lowCount != 4) begin errors++; $display("FAIL long_low_count got %0d want 4", lowCount); end
    endtask

    task automatic test_ignore_busy();
        int pulses = 0;
        int csLowCount = 0;
        bus0.req_valid = 1; bus0.req_write = 1; bus0.req_addr = 2'd0; bus0.req_wdata = 8'h55;
        tick();
        bus0.req_valid = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (cyc == 2) begin
                bus0.req_valid = 1; bus0.req_write = 0; bus0.req_addr = 2'd3;
                checks++; if (bus0.req_ready !== 1'b0) begin errors++; $display("FAIL busy_ready got %b want 0", bus0.req_ready); end
            end
            if (cyc == 3) bus0.req_valid = 0;
            if (cyc == 4) begin
                checks++; if (bus0.A !== 2'd0) begin errors++; $display("FAIL busy_addr got %0d want 0", bus0.A); end
            end
            if (bus0.CS === 1'b0) csLowCount++;
            if (bus0.rsp_valid === 1'b1) pulses++;
            checks++; if (bus0.READ !== 1'b1) begin errors++; $display("FAIL busy_read cyc %0d got %b want 1", cyc, bus0.READ); end
            tick();
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL busy_pulses got %0d want 1", pulses); end
        checks++; if (csLowCount != 4) begin errors++; $display("FAIL busy_cs_low got %0d want 4", csLowCount); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_long_read();
        test_ignore_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
